// File: rtl/dspbb_pkg.sv
// Shared constants and elaboration-time helpers for the DSP building blocks.
package dspbb_pkg;

  localparam int unsigned ARITH_UNSIGNED = 0;
  localparam int unsigned ARITH_SIGNED   = 1;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width needed to hold the exact sum of count operands of the given width.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned count);
    return width + clog2(count);
  endfunction

  // Adder-tree depth; a single operand still gets one register stage.
  function automatic int unsigned tree_levels(input int unsigned count);
    return (count <= 1) ? 1 : clog2(count);
  endfunction

  // Number of nodes present at a tree level (level 0 = raw operands).
  function automatic int unsigned node_count(input int unsigned count, input int unsigned lvl);
    return (count + (32'd1 << lvl) - 1) >> lvl;
  endfunction

  // Bit offset of a tree level inside the flattened tree bus.
  function automatic int unsigned level_offset(input int unsigned width, input int unsigned count,
                                               input int unsigned lvl);
    int unsigned acc;
    acc = 0;
    for (int unsigned i = 0; i < lvl; i++) begin
      acc += node_count(count, i) * (width + i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/reg_adder2.sv
// Registered two-input adder with one bit of growth; clock-enable stalls it.
module reg_adder2
  import dspbb_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned SIGNED = ARITH_UNSIGNED
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ce,
  input  logic [IN_W-1:0] i_a,
  input  logic [IN_W-1:0] i_b,
  output logic [IN_W:0]   o_sum
);

  logic [IN_W:0] a_ext;
  logic [IN_W:0] b_ext;
  logic [IN_W:0] sum_d;
  logic [IN_W:0] sum_q;

  // Extend both operands by one bit, then add when enabled.
  always_comb begin
    if (SIGNED == ARITH_SIGNED) begin
      a_ext = {i_a[IN_W-1], i_a};
      b_ext = {i_b[IN_W-1], i_b};
    end else begin
      a_ext = {1'b0, i_a};
      b_ext = {1'b0, i_b};
    end
    sum_d = sum_q;
    if (i_ce) sum_d = a_ext + b_ext;
  end

  // Sum register, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign o_sum = sum_q;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined binary adder tree: sums NUM_IN operands per enabled cycle with
// full bit growth; latency is LEVELS enabled cycles, valid travels alongside.
module adder_tree_pipelined
  import dspbb_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SIGNED = ARITH_UNSIGNED
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_ce,
  input  logic                                  i_valid,
  input  logic [NUM_IN*WIDTH-1:0]               i_data,
  output logic                                  o_valid,
  output logic [sum_width(WIDTH, NUM_IN)-1:0]   o_sum
);

  localparam int unsigned LEVELS    = tree_levels(NUM_IN);
  localparam int unsigned OUTW      = sum_width(WIDTH, NUM_IN);
  localparam int unsigned FINAL_W   = WIDTH + LEVELS;
  localparam int unsigned FINAL_OFF = level_offset(WIDTH, NUM_IN, LEVELS);
  localparam int unsigned BUS_W     = FINAL_OFF + node_count(NUM_IN, LEVELS) * FINAL_W;

  // Every tree level is packed back to back in one bus so each level can
  // have its own node count and width; level 0 is the raw input operands.
  logic [BUS_W-1:0]   tree_bus;
  logic [FINAL_W-1:0] final_sum;
  logic [LEVELS-1:0]  valid_d;
  logic [LEVELS-1:0]  valid_q;

  assign tree_bus[NUM_IN*WIDTH-1:0] = i_data;

  for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
    localparam int unsigned IN_W    = WIDTH + j;
    localparam int unsigned N_IN    = node_count(NUM_IN, j);
    localparam int unsigned N_OUT   = node_count(NUM_IN, j + 1);
    localparam int unsigned IN_OFF  = level_offset(WIDTH, NUM_IN, j);
    localparam int unsigned OUT_OFF = level_offset(WIDTH, NUM_IN, j + 1);

    for (genvar k = 0; k < N_OUT; k++) begin : g_node
      logic [IN_W-1:0] op_a;
      logic [IN_W-1:0] op_b;
      logic [IN_W:0]   node_sum;

      assign op_a = tree_bus[IN_OFF + 2*k*IN_W +: IN_W];

      // An unpaired operand adds zero so it still gets extended and registered.
      if (2*k + 1 < N_IN) begin : g_pair
        assign op_b = tree_bus[IN_OFF + (2*k+1)*IN_W +: IN_W];
      end else begin : g_single
        assign op_b = '0;
      end

      reg_adder2 #(
        .IN_W   (IN_W),
        .SIGNED (SIGNED)
      ) u_add (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_a     (op_a),
        .i_b     (op_b),
        .o_sum   (node_sum)
      );

      assign tree_bus[OUT_OFF + k*(IN_W+1) +: IN_W+1] = node_sum;
    end
  end

  assign final_sum = tree_bus[FINAL_OFF +: FINAL_W];

  // A lone operand gets one stage of growth it cannot use; the dropped MSB
  // is only a copy of the extension bit, so the value is unchanged.
  if (FINAL_W == OUTW) begin : g_out_full
    assign o_sum = final_sum;
  end else begin : g_out_trim
    logic unused_ext_bit;
    assign unused_ext_bit = final_sum[FINAL_W-1];
    assign o_sum          = final_sum[OUTW-1:0];
  end

  // Valid shift register, stalled together with the data path.
  always_comb begin
    valid_d = valid_q;
    if (i_ce) valid_d = (valid_q << 1) | LEVELS'(i_valid);
  end

  // Valid pipeline registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  assign o_valid = valid_q[LEVELS-1];

endmodule

// File: doc/adder_tree_pipelined.md
Name: adder_tree_pipelined

Overview:
- Parametrised successor to the two-input combinational adder: sums NUM_IN operands per clock through a registered binary adder tree.
- Full bit growth, no truncation.
- Supports unsigned or two's-complement operands, clock-enable stall and a valid pipeline.
- Sits in front of decimators, moving-average filters and correlator accumulators in the DSP Building Blocks library.

Parameters:
- NUM_IN, 8, number of operands (1..64; need not be a power of two)
- WIDTH, 16, width of each operand in bits (2..48)
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands
- LEVELS, derived localparam = clog2(NUM_IN), minimum 1; tree depth and latency in cycles
- OUTW, derived localparam = WIDTH + clog2(NUM_IN); output width

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_ce  in  1  clock enable; low freezes the whole pipeline
- i_valid  in  1  qualifies i_data this cycle (sampled only when i_ce=1)
- i_data  in  NUM_IN*WIDTH  flattened operands; operand k is i_data[k*WIDTH +: WIDTH]
- o_valid  out  1  o_sum holds a valid result
- o_sum  out  OUTW  sum of the NUM_IN operands captured LEVELS enabled cycles earlier

Behaviour:
- Reset:
  - All tree registers, o_sum and o_valid are cleared to 0 asynchronously on i_reset=1.
  - Registers stay 0 while i_reset is high; the first capture is on the first rising edge with i_reset=0 and i_ce=1.
- Tree structure:
  - Level 0 pairs operands (0,1), (2,3), …
  - Each level halves the operand count (ceil) and is registered.
  - Level j results are WIDTH+j+1 bits wide.
- Odd count at any level: the unpaired operand is extended by one bit and registered unchanged, so all paths carry equal latency.
- NUM_IN=1: o_sum is the extended operand, registered once (latency 1).
- Extension rule:
  - SIGNED=0: zero-extend at every level.
  - SIGNED=1: sign-extend at every level.
  - Final extension to OUTW uses the same rule.
  - Overflow is impossible by construction.
- Latency: exactly LEVELS enabled cycles from i_data capture to o_sum/o_valid.
- Throughput: one new operand set per enabled cycle, no bubbles.
- Valid pipeline:
  - A LEVELS-deep shift register carries i_valid alongside the data.
  - Data registers load every enabled cycle regardless of valid.
  - Consumers must qualify o_sum with o_valid.
- i_ce=0: every data and valid register holds; o_sum and o_valid are unchanged. Resuming with i_ce=1 continues with no lost or duplicated results.
- Reset mid-operation: in-flight results are discarded and o_valid=0 immediately; no partial sums reappear after release.
- No handshake back-pressure: downstream must accept every o_valid beat or drive i_ce low.

Decomposition:
- Shared package dspbb_pkg:
  - clog2 constant function
  - helper that computes the output width from (WIDTH, count)
  - SIGNED encoding constants ARITH_UNSIGNED=0 and ARITH_SIGNED=1
- Sub-module reg_adder2:
  - Registered two-input adder with parameters IN_W and SIGNED, ports i_clk, i_reset, i_ce, i_a, i_b, o_sum[IN_W:0].
  - The single-operand pass-through case ties i_b=0.
  - Generated per pair per level by the top level.

Test Plan:
- Unsigned full scale: NUM_IN=8, WIDTH=16, SIGNED=0, all operands 0xFFFF, i_valid=1 → o_sum=0x7FFF8 (19 bits), o_valid=1 exactly 3 cycles later.
- Signed extremes: NUM_IN=8, WIDTH=16, SIGNED=1.
  - All 0x8000 → o_sum = 19'h40000 (−262144).
  - Alternating 0x7FFF/0x8000 → o_sum = 19'h7FFFC (−4).
- Odd count: NUM_IN=5, WIDTH=8, SIGNED=0, operands 1,2,3,4,255 → o_sum = 265 (11 bits) after 3 cycles.
- Streaming: NUM_IN=4, back-to-back sets of all-k for k=1..10, i_valid=1 → o_valid high for 10 consecutive cycles from cycle 2, o_sum=4k in order.
- Stall: mid-stream, hold i_ce=0 for 5 cycles → o_sum/o_valid frozen throughout; the sequence resumes with no gaps or repeats versus the reference model.
- Reset mid-flight: assert i_reset for 1 cycle while two valid sets are in the pipe → o_valid=0 and o_sum=0 asynchronously; no result for those sets ever appears.
